// File: rtl/tail_light_scheduler_pkg.sv
// Shared types, defaults and helpers for the tail-light sweep scheduler.
package tail_light_pkg;

    localparam int unsigned DEF_NUM_LAMPS   = 3;
    localparam int unsigned DEF_STEP_CYCLES = 5;
    localparam int unsigned MAX_LAMPS       = 16;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_e;

    // Thermometer pattern with the lowest 'step' bits set.
    function automatic logic [MAX_LAMPS-1:0] thermometer(input int unsigned step);
        logic [MAX_LAMPS:0] one_hot;
        one_hot = (MAX_LAMPS+1)'(1) << step;
        return MAX_LAMPS'(one_hot - (MAX_LAMPS+1)'(1));
    endfunction

    // Priority decode of driver requests; both turns together behave as hazard.
    function automatic mode_e decode_request(input logic turn_left,
                                             input logic turn_right,
                                             input logic hazard);
        if (hazard || (turn_left && turn_right)) return MODE_HAZARD;
        if (turn_left)                           return MODE_LEFT;
        if (turn_right)                          return MODE_RIGHT;
        return MODE_IDLE;
    endfunction

endpackage

// File: rtl/tail_light_scheduler_if.sv
// Switch-input / lamp-driver bundle of the tail-light scheduler.
interface tail_light_if
    import tail_light_pkg::*;
#(
    parameter int unsigned NUM_LAMPS = DEF_NUM_LAMPS
);
    logic                 turn_left;
    logic                 turn_right;
    logic                 hazard;
    logic                 brake;
    logic [NUM_LAMPS-1:0] left_lamps;
    logic [NUM_LAMPS-1:0] right_lamps;
    logic [1:0]           mode;
    logic                 sweep_done;

    modport master (
        output turn_left, turn_right, hazard, brake,
        input  left_lamps, right_lamps, mode, sweep_done
    );

    modport slave (
        input  turn_left, turn_right, hazard, brake,
        output left_lamps, right_lamps, mode, sweep_done
    );
endinterface

// File: rtl/tail_light_scheduler_step_timer.sv
// Prescaler plus sweep-step counter; exposes the next step so the top can register lamps.
module tail_light_step_timer
    import tail_light_pkg::*;
#(
    parameter int unsigned NUM_LAMPS   = DEF_NUM_LAMPS,
    parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    input  logic                               enable,
    output logic [$clog2(NUM_LAMPS+1)-1:0]     step_nxt_c,
    output logic                               last_step_done_c,
    output logic                               sweep_done
);
    localparam int unsigned SW = $clog2(NUM_LAMPS + 1);
    localparam int unsigned PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [SW-1:0] step_q;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_nxt_c;
    logic          done_nxt_c;

    // Advance prescaler; roll the step when the prescaler reaches its terminal count.
    always_comb begin
        pre_nxt_c  = pre_q;
        step_nxt_c = step_q;
        if (clear) begin
            pre_nxt_c  = '0;
            step_nxt_c = '0;
        end else if (enable) begin
            if (pre_q == PW'(STEP_CYCLES - 1)) begin
                pre_nxt_c  = '0;
                step_nxt_c = (step_q == SW'(NUM_LAMPS)) ? '0 : step_q + SW'(1);
            end else begin
                pre_nxt_c = pre_q + PW'(1);
            end
        end
        done_nxt_c = (step_nxt_c == SW'(NUM_LAMPS)) && (pre_nxt_c == PW'(STEP_CYCLES - 1));
    end

    assign last_step_done_c = (step_q == SW'(NUM_LAMPS)) && (pre_q == PW'(STEP_CYCLES - 1));

    // Timer state and the registered end-of-sweep pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q     <= '0;
            pre_q      <= '0;
            sweep_done <= 1'b0;
        end else begin
            step_q     <= step_nxt_c;
            pre_q      <= pre_nxt_c;
            sweep_done <= done_nxt_c;
        end
    end

endmodule

// File: rtl/tail_light_scheduler.sv
// Owner FSM, request decode and registered lamp/brake mux for the tail-light sweep.
module tail_light_scheduler
    import tail_light_pkg::*;
#(
    parameter int unsigned NUM_LAMPS   = DEF_NUM_LAMPS,
    parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    tail_light_if.slave bus
);
    localparam int unsigned SW = $clog2(NUM_LAMPS + 1);

    mode_e                mode_q;
    mode_e                mode_d;
    mode_e                req_c;
    logic                 clear_c;
    logic                 enable_c;
    logic [SW-1:0]        step_nxt_c;
    logic                 last_step_done_c;
    logic                 sweep_done_q;
    logic [NUM_LAMPS-1:0] pat_c;
    logic [NUM_LAMPS-1:0] fill_c;
    logic [NUM_LAMPS-1:0] left_d;
    logic [NUM_LAMPS-1:0] right_d;
    logic [NUM_LAMPS-1:0] left_q;
    logic [NUM_LAMPS-1:0] right_q;

    tail_light_step_timer #(
        .NUM_LAMPS   (NUM_LAMPS),
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (clear_c),
        .enable           (enable_c),
        .step_nxt_c       (step_nxt_c),
        .last_step_done_c (last_step_done_c),
        .sweep_done       (sweep_done_q)
    );

    assign req_c = decode_request(bus.turn_left, bus.turn_right, bus.hazard);

    // Owner locked for a whole sweep; re-decode only from IDLE or at sweep end.
    always_comb begin
        mode_d   = mode_q;
        clear_c  = 1'b0;
        enable_c = 1'b0;
        case (mode_q)
            MODE_IDLE: begin
                mode_d  = req_c;
                clear_c = 1'b1;
            end
            default: begin
                enable_c = 1'b1;
                if (last_step_done_c) begin
                    mode_d  = req_c;
                    clear_c = 1'b1;
                end
            end
        endcase
    end

    // Lamp pattern for the post-edge state with brake filling unowned sides.
    always_comb begin
        pat_c   = NUM_LAMPS'(thermometer(32'(step_nxt_c)));
        fill_c  = bus.brake ? '1 : '0;
        left_d  = fill_c;
        right_d = fill_c;
        case (mode_d)
            MODE_LEFT:   left_d  = pat_c;
            MODE_RIGHT:  right_d = pat_c;
            MODE_HAZARD: begin
                left_d  = pat_c;
                right_d = pat_c;
            end
            default: ;
        endcase
    end

    // Owner state and registered lamp drives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= MODE_IDLE;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            mode_q  <= mode_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign bus.left_lamps  = left_q;
    assign bus.right_lamps = right_q;
    assign bus.mode        = 2'(mode_q);
    assign bus.sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_tail_light_scheduler.sv
// Directed scenarios plus random stimulus against a sweep-time reference model.
module tb_tail_light_scheduler;
    import tail_light_pkg::*;

    localparam int N = 3;
    localparam int S = 5;
    localparam int P = (N + 1) * S;
    localparam int ONES = (1 << N) - 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    int   m_owner;
    int   m_t;
    bit   m_brk;

    tail_light_if #(.NUM_LAMPS(N)) bus ();

    tail_light_scheduler #(.NUM_LAMPS(N), .STEP_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input bit l, input bit r, input bit h);
        if (h || (l && r)) return 3;
        if (l) return 1;
        if (r) return 2;
        return 0;
    endfunction

    // Model: owner plus elapsed cycle within the current sweep.
    task automatic model_edge();
        if (!rst_n) begin
            m_owner = 0;
            m_t     = 0;
            m_brk   = 0;
        end else begin
            m_brk = bus.brake;
            if (m_owner == 0 || m_t == P - 1) begin
                m_owner = decode(bus.turn_left, bus.turn_right, bus.hazard);
                m_t     = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic compare();
        int pat;
        int fill;
        int el;
        int er;
        pat  = (1 << (m_t / S)) - 1;
        fill = m_brk ? ONES : 0;
        el   = (m_owner == 1 || m_owner == 3) ? pat : fill;
        er   = (m_owner == 2 || m_owner == 3) ? pat : fill;
        check("mode", int'(bus.mode), m_owner);
        check("left_lamps", int'(bus.left_lamps), el);
        check("right_lamps", int'(bus.right_lamps), er);
        check("sweep_done", int'(bus.sweep_done), (m_owner != 0 && m_t == P - 1) ? 1 : 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic set_in(input bit l, input bit r, input bit h, input bit b);
        bus.turn_left  = l;
        bus.turn_right = r;
        bus.hazard     = h;
        bus.brake      = b;
    endtask

    task automatic settle();
        set_in(0, 0, 0, 0);
        for (int i = 0; i < P + 5; i++) cyc();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_owner = 0;
        m_t     = 0;
        m_brk   = 0;
        rst_n   = 1'b0;
        set_in(1, 1, 1, 1);
        #2;

        // Reset with every request active.
        for (int i = 0; i < 3; i++) cyc();
        check("rst_mode", int'(bus.mode), 0);
        check("rst_left", int'(bus.left_lamps), 0);
        check("rst_right", int'(bus.right_lamps), 0);
        check("rst_done", int'(bus.sweep_done), 0);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0);
        cyc();

        // Right turn held for two sweeps.
        set_in(0, 1, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (k == 1)  check("s2_entry_right", int'(bus.right_lamps), 0);
            if (k == 6)  check("s2_step1_right", int'(bus.right_lamps), 1);
            if (k == 16) check("s2_step3_right", int'(bus.right_lamps), 7);
            if (k == 16) check("s2_left_off", int'(bus.left_lamps), 0);
            if (k == 19) check("s2_no_done_early", int'(bus.sweep_done), 0);
            if (k == 20) check("s2_done_20", int'(bus.sweep_done), 1);
            if (k == 21) check("s2_wrap_right", int'(bus.right_lamps), 0);
            if (k == 21) check("s2_wrap_mode", int'(bus.mode), 2);
            if (k == 40) check("s2_done_40", int'(bus.sweep_done), 1);
        end
        settle();

        // Left turn dropped early still completes a full sweep.
        set_in(1, 0, 0, 0);
        for (int k = 1; k <= 21; k++) begin
            cyc();
            if (k == 7) bus.turn_left = 1'b0;
            if (k == 20) check("s3_mode_20", int'(bus.mode), 1);
            if (k == 20) check("s3_left_20", int'(bus.left_lamps), 7);
            if (k == 21) check("s3_mode_idle", int'(bus.mode), 0);
            if (k == 21) check("s3_left_off", int'(bus.left_lamps), 0);
        end
        settle();

        // Left turn with brake: right side solid, released on the next edge.
        set_in(1, 0, 0, 1);
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (k == 3)  check("s4_right_brake", int'(bus.right_lamps), 7);
            if (k == 11) check("s4_left_step2", int'(bus.left_lamps), 3);
        end
        bus.brake = 1'b0;
        cyc();
        check("s4_brake_release", int'(bus.right_lamps), 0);
        settle();

        // Hazard raised mid left sweep waits, then ignores brake.
        set_in(1, 0, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (k == 8)  bus.hazard = 1'b1;
            if (k == 25) bus.brake = 1'b1;
            if (k == 20) check("s5_still_left", int'(bus.mode), 1);
            if (k == 20) check("s5_right_off", int'(bus.right_lamps), 0);
            if (k == 21) check("s5_hazard", int'(bus.mode), 3);
            if (k == 26) check("s5_left_lock", int'(bus.left_lamps), 1);
            if (k == 26) check("s5_right_lock", int'(bus.right_lamps), 1);
        end
        settle();

        // Reset pulse in step 2 of a right sweep, then restart.
        set_in(0, 1, 0, 0);
        for (int k = 1; k <= 12; k++) cyc();
        check("s6_pre_rst_step2", int'(bus.right_lamps), 3);
        rst_n = 1'b0;
        cyc();
        check("s6_rst_mode", int'(bus.mode), 0);
        check("s6_rst_right", int'(bus.right_lamps), 0);
        rst_n = 1'b1;
        cyc();
        check("s6_restart_mode", int'(bus.mode), 2);
        check("s6_restart_right", int'(bus.right_lamps), 0);
        for (int k = 0; k < 5; k++) cyc();
        check("s6_restart_step1", int'(bus.right_lamps), 1);
        settle();

        // Random requests, brake and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) bus.turn_left  = ~bus.turn_left;
            if ($urandom_range(0, 11) == 0) bus.turn_right = ~bus.turn_right;
            if ($urandom_range(0, 19) == 0) bus.hazard     = ~bus.hazard;
            if ($urandom_range(0, 7)  == 0) bus.brake      = ~bus.brake;
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
